seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//   Time-multiplexed controller for a multi-digit common-anode seven-segment display.
//   Shares one hex-to-segment decoder across NUM_DIGITS digits: scans one digit at a time,
//   with a blanking gap between digits to suppress ghosting.
//   Accepts new display values over a valid/ready handshake and commits them only at frame
//   boundaries (no tearing). Sits between the user datapath and the board display pins.
// PARAMETERS
//   NUM_DIGITS      8      digits scanned per frame (>=2)
//   REFRESH_CYCLES  12500  clk_in cycles per digit slot, blank + show (> BLANK_CYCLES)
//   BLANK_CYCLES    16     cycles at start of each slot with all anodes off (>=1)
// PORTS
//   clk_in          in   1              system clock; single clock domain
//   rst_n_in        in   1              reset, asynchronous, active-low
//   upd_val_in      in   4*NUM_DIGITS   new nibbles; digit i = [4i+3:4i]
//   upd_en_in       in   NUM_DIGITS     new per-digit enable mask (1 = lit)
//   upd_valid_in    in   1              update request
//   upd_ready_out   out  1              update accepted when valid&ready
//   an_out          out  NUM_DIGITS     anodes, active-low, one-hot-low or all-high
//   cat_out         out  7              cathodes, active-low; cat_out[0]=a ... [6]=g
//   frame_done_out  out  1              1-cycle pulse on the last cycle of each frame
// BEHAVIOUR
//   Reset (async assert, sync-safe release):
//     an_out='1; cat_out=7'h7F; frame_done_out=0; upd_ready_out=1;
//     digit index=0; state=BLANK; slot counter=0; display and pending regs cleared;
//     enable mask reg cleared (all digits dark).
//   Reset mid-frame: same values immediately; any pending update is discarded.
//   FSM per slot:
//     BLANK: BLANK_CYCLES cycles; an_out='1, cat_out=7'h7F.
//     SHOW: REFRESH_CYCLES-BLANK_CYCLES cycles.
//       an_out[idx]=0 if mask[idx]=1, else all high.
//       cat_out = ~segments(display[idx]), using the standard hex glyphs 0-9, A, b, C, d, E, F.
//   Slot timing:
//     Slot counter is $clog2(REFRESH_CYCLES) bits and counts 0..REFRESH_CYCLES-1.
//     At count BLANK_CYCLES-1 the FSM goes BLANK->SHOW.
//     At count REFRESH_CYCLES-1: SHOW->BLANK, counter->0, idx increments.
//     idx wraps NUM_DIGITS-1 -> 0.
//   Disabled digits still consume their slot, so duty cycle and brightness are constant.
//   an_out and cat_out are registered and change together on the cycle the state changes.
//   No cycle ever has two anodes low.
//   Frame end is the cycle with idx=NUM_DIGITS-1 and count=REFRESH_CYCLES-1.
//     frame_done_out=1 on that cycle only.
//   Update handshake:
//     On valid&ready, val/en are captured into the pending regs.
//     upd_ready_out drops the next cycle and stays low until the commit.
//     At the frame-end cycle, pending is copied to the display/mask regs and upd_ready_out
//     returns high the next cycle.
//     A handshake on the frame-end cycle itself bypasses pending: it commits directly at
//     that boundary and upd_ready_out stays high.
//     No pending update at frame end: display unchanged.
//     upd_valid_in while ready=0 is ignored; the requester must hold it.
//   The new frame after a commit starts with digit 0 using the new values.
//     The current frame is never altered mid-scan.
// TESTING
//   Bench params: NUM_DIGITS=4, REFRESH_CYCLES=10, BLANK_CYCLES=2.
//   T1 Reset:
//     assert rst_n_in mid-SHOW -> same cycle an_out=4'hF, cat_out=7'h7F, ready=1.
//     After release, first SHOW begins at cycle 2.
//   T2 Scan order:
//     update val=16'h3210, en=4'hF, then run 2 frames.
//     an_out sequence E,D,B,7, each low for 8 cycles, separated by 2 cycles of F.
//     cat_out for digit 0 = 7'h40, for digit 1 = 7'h79.
//     frame_done pulses every 40 cycles.
//   T3 Mask:
//     en=4'b0101 -> digits 1 and 3 keep an_out=F through their slots.
//     Slot length stays 10 cycles.
//   T4 No tearing:
//     handshake val=16'hABCD mid-frame (idx=1) -> ready low until frame end.
//     Digit 2 still shows the old value.
//     The next frame shows D,C,B,A and ready returns high.
//   T5 Boundary handshake:
//     valid on the frame-end cycle -> accepted, ready stays 1.
//     The next frame's digit 0 shows the new value.
//   T6 Back-pressure:
//     hold valid with changing data while ready=0 -> only the value present at the
//     ready=1 handshake is displayed.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with a shared hex decoder,
// per-slot blanking and frame-synchronous (tear-free) display updates.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 12500,
    parameter int BLANK_CYCLES   = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [4*NUM_DIGITS-1:0] upd_val_in,
    input  logic [NUM_DIGITS-1:0]   upd_en_in,
    input  logic                    upd_valid_in,
    output logic                    upd_ready_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              cat_out,
    output logic                    frame_done_out
);

    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_en;
    logic                    r_ready;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_cat;
    logic                    r_frame_done;

    state_t                  w_state_next;
    logic [CW-1:0]           w_cnt_next;
    logic [IW-1:0]           w_idx_next;
    logic [4*NUM_DIGITS-1:0] w_disp_next;
    logic [NUM_DIGITS-1:0]   w_mask_next;
    logic                    w_frame_end;
    logic                    w_accept;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg;
    logic [3:0]              w_nibbles [NUM_DIGITS];

    assign w_frame_end = (r_idx == IDX_LAST) && (r_cnt == CNT_LAST);
    assign w_accept    = upd_valid_in & r_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign w_nibbles[gi] = w_disp_next[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        w_cnt_next   = r_cnt + CW'(1);
        w_idx_next   = r_idx;
        w_state_next = r_state;
        if (r_cnt == CNT_LAST) begin
            w_cnt_next   = '0;
            w_state_next = ST_BLANK;
            w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end else if (r_cnt == CNT_BLANK) begin
            w_state_next = ST_SHOW;
        end
    end

    // A handshake landing on the frame-end cycle commits directly; otherwise pending wins.
    always_comb begin
        w_disp_next = r_disp;
        w_mask_next = r_mask;
        if (w_frame_end) begin
            if (w_accept) begin
                w_disp_next = upd_val_in;
                w_mask_next = upd_en_in;
            end else if (!r_ready) begin
                w_disp_next = r_pend_val;
                w_mask_next = r_pend_en;
            end
        end
    end

    assign w_nib = w_nibbles[w_idx_next];

    always_comb begin
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
    end

    // Outputs are computed from next-state values so they switch with the state itself.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_mask       <= '0;
            r_pend_val   <= '0;
            r_pend_en    <= '0;
            r_ready      <= 1'b1;
            r_an         <= '1;
            r_cat        <= 7'h7F;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_disp       <= w_disp_next;
            r_mask       <= w_mask_next;
            r_frame_done <= (w_idx_next == IDX_LAST) && (w_cnt_next == CNT_LAST);
            if (w_state_next == ST_SHOW) begin
                r_an  <= w_mask_next[w_idx_next] ? ~(NUM_DIGITS'(1) << w_idx_next) : '1;
                r_cat <= ~w_seg;
            end else begin
                r_an  <= '1;
                r_cat <= 7'h7F;
            end
            if (w_accept && !w_frame_end) begin
                r_pend_val <= upd_val_in;
                r_pend_en  <= upd_en_in;
                r_ready    <= 1'b0;
            end else if (w_frame_end) begin
                r_ready    <= 1'b1;
            end
        end
    end

    assign upd_ready_out  = r_ready;
    assign an_out         = r_an;
    assign cat_out        = r_cat;
    assign frame_done_out = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench: every cycle compares the scanner against a frame-position model
// (position = cycles since reset modulo one frame) driven by directed and random updates.
module tb_seven_seg_scanner;

    localparam int ND = 4;
    localparam int RC = 10;
    localparam int BC = 2;
    localparam int FR = ND * RC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] upd_val = '0;
    logic [3:0]  upd_en = '0;
    logic        upd_valid = 1'b0;
    logic        ready;
    logic [3:0]  an;
    logic [6:0]  cat;
    logic        fd;

    int n_tests = 0;
    int n_fail  = 0;

    int          mp;
    logic [3:0]  m_disp [ND];
    logic [3:0]  m_mask;
    logic        m_ready;
    logic [15:0] m_pval;
    logic [3:0]  m_pen;
    logic        m_acc;
    logic [6:0]  glyph [16];

    seven_seg_scanner #(
        .NUM_DIGITS    (ND),
        .REFRESH_CYCLES(RC),
        .BLANK_CYCLES  (BC)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .upd_val_in    (upd_val),
        .upd_en_in     (upd_en),
        .upd_valid_in  (upd_valid),
        .upd_ready_out (ready),
        .an_out        (an),
        .cat_out       (cat),
        .frame_done_out(fd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t pos=%0d actual=%0h expected=%0h", tag, $time, mp, act, exp);
        end
    endtask

    task automatic model_reset();
        mp      = 0;
        m_mask  = '0;
        m_ready = 1'b1;
        m_pval  = '0;
        m_pen   = '0;
        for (int i = 0; i < ND; i++) m_disp[i] = '0;
    endtask

    task automatic model_commit(input logic [15:0] val, input logic [3:0] en);
        for (int i = 0; i < ND; i++) m_disp[i] = val[4*i +: 4];
        m_mask = en;
    endtask

    // Called at a falling edge: check this cycle, drive inputs for the coming edge, advance.
    task automatic step(input logic v, input logic [15:0] val, input logic [3:0] en);
        int         idx;
        int         c;
        logic       show;
        logic       fe;
        logic [3:0] ea;
        logic [6:0] ec;
        idx  = mp / RC;
        c    = mp % RC;
        show = (c >= BC);
        fe   = (mp == FR - 1);
        ea   = (show && m_mask[idx]) ? ~(4'b0001 << idx) : 4'hF;
        ec   = show ? ~glyph[m_disp[idx]] : 7'h7F;
        check_val("an", 32'(an), 32'(ea));
        check_val("cat", 32'(cat), 32'(ec));
        check_val("frame_done", 32'(fd), 32'(fe));
        check_val("ready", 32'(ready), 32'(m_ready));

        upd_valid = v;
        upd_val   = val;
        upd_en    = en;
        m_acc     = v && m_ready;
        if (m_acc)
            $display("[TB] update accepted val=%h en=%b pos=%0d%s", val, en, mp, fe ? " (frame end)" : "");
        if (m_acc && fe) begin
            model_commit(val, en);
        end else if (m_acc) begin
            m_pval  = val;
            m_pen   = en;
            m_ready = 1'b0;
        end else if (fe && !m_ready) begin
            model_commit(m_pval, m_pen);
            m_ready = 1'b1;
        end
        mp = (mp + 1) % FR;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic wait_pos(input int target);
        for (int k = 0; k < FR && mp != target; k++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic send(input logic [15:0] val, input logic [3:0] en);
        m_acc = 1'b0;
        for (int k = 0; k < 4 * FR && !m_acc; k++) step(1'b1, val, en);
        if (!m_acc) check_val("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_reset();
        m_acc = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_an", 32'(an), 32'hF);
        check_val("rst_cat", 32'(cat), 32'h7F);
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_fd", 32'(fd), 32'd0);
        rst_n = 1'b1;

        // Scan order with all digits lit
        send(16'h3210, 4'hF);
        idle(3 * FR);

        // Asynchronous reset in the middle of digit 1's SHOW phase
        wait_pos(15);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_an", 32'(an), 32'hF);
        check_val("async_rst_cat", 32'(cat), 32'h7F);
        check_val("async_rst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(FR + 5);

        // Enable mask
        send(16'h7654, 4'b0101);
        idle(2 * FR);

        // Mid-frame update must wait for the frame boundary
        wait_pos(11);
        send(16'hABCD, 4'hF);
        idle(FR + 5);

        // Handshake on the frame-end cycle commits directly
        wait_pos(FR - 1);
        step(1'b1, 16'h1234, 4'hF);
        check_val("boundary_accept", 32'(m_acc), 32'd1);
        idle(FR);

        // Back-pressure: data changes while ready is low are ignored
        wait_pos(5);
        send(16'h9999, 4'hF);
        for (int k = 0; k < 40; k++) step(1'b1, 16'($urandom), 4'($urandom));
        idle(2 * FR);

        // Randomized updates
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) step(1'b1, 16'($urandom), 4'($urandom));
            else                           step(1'b0, 16'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
